// File: rtl/ff_comb_pipe_pkg.sv
// Shared types and helpers for the registered comparator/select/decode pipeline.
package ff_comb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [2:0] LSB_CODE_MAX = 3'd7;

  // Inverted 3-bit code of the operand LSBs.
  function automatic logic [2:0] lsb_decode(input logic [2:0] lsbs);
    return LSB_CODE_MAX - lsbs;
  endfunction

endpackage

// File: rtl/ff_comb_pipe_if.sv
// Handshake and data bus of ff_comb_pipe; the source/sink side uses master.
interface ff_comb_pipe_if #(
  parameter int unsigned size = 4
) ();

  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] src1;
  logic [size-1:0] src2;
  logic [size-1:0] src3;
  logic            flush;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] out1;
  logic [size-1:0] out2;
  logic [size-1:0] out3;
  logic [size-1:0] out4;
  logic [size-1:0] out5;
  logic            busy;

  modport master (
    output in_valid, src1, src2, src3, flush, clear, out_ready,
    input  in_ready, out_valid, out1, out2, out3, out4, out5, busy
  );

  modport slave (
    input  in_valid, src1, src2, src3, flush, clear, out_ready,
    output in_ready, out_valid, out1, out2, out3, out4, out5, busy
  );

endinterface

// File: rtl/ff_comb_pipe_stage.sv
// One valid/payload pipeline register; loads when enabled, payload only on a valid entry.
module ff_comb_stage #(
  parameter int unsigned width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [width-1:0] in_payload,
  output logic             out_valid,
  output logic [width-1:0] out_payload
);

  logic             valid_q, valid_d;
  logic [width-1:0] payload_q, payload_d;

  // Payload is kept when a bubble moves in so outputs hold the last delivered value.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) payload_d = in_payload;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/ff_comb_pipe.sv
// Flow-controlled compare/select/decode pipeline with counter, running max and flush FSM.
module ff_comb_pipe
  import ff_comb_pkg::*;
#(
  parameter int unsigned size  = 4,
  parameter int unsigned depth = 2
) (
  input  logic           clk,
  input  logic           reset,
  ff_comb_pipe_if.slave  bus
);

  localparam int unsigned payload_w = 3 * size;

  state_t                state_q, state_d;
  logic [size-1:0]       count_q, count_d;
  logic [size-1:0]       max_q, max_d;
  logic                  accept;
  logic                  pipe_empty_d;
  logic [depth-1:0]      stg_valid;
  logic [depth-1:0]      stg_en;
  logic [payload_w-1:0]  stg_payload [depth];
  logic [payload_w-1:0]  entry_payload;
  logic [size-1:0]       sel;
  logic [2:0]            code;

  // Per-transaction functions evaluated at pipe entry.
  always_comb begin
    sel           = (bus.src1 < bus.src2) ? bus.src1 : bus.src3;
    code          = lsb_decode({bus.src1[0], bus.src2[0], bus.src3[0]});
    entry_payload = {bus.src1, sel, size'(code)};
  end

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    logic adv;
    stg_en = '0;
    adv    = bus.out_ready;
    for (int k = int'(depth) - 1; k >= 0; k--) begin
      stg_en[k] = ~stg_valid[k] | adv;
      adv       = stg_en[k];
    end
  end

  always_comb begin
    bus.in_ready = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready = stg_en[0];
      ACTIVE:  bus.in_ready = stg_en[0] & ~bus.flush;
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < int'(depth); k++) begin : g_stage
    if (k == 0) begin : g_first
      ff_comb_stage #(.width(payload_w)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .en         (stg_en[k]),
        .in_valid   (accept),
        .in_payload (entry_payload),
        .out_valid  (stg_valid[k]),
        .out_payload(stg_payload[k])
      );
    end else begin : g_next
      ff_comb_stage #(.width(payload_w)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .en         (stg_en[k]),
        .in_valid   (stg_valid[k-1]),
        .in_payload (stg_payload[k-1]),
        .out_valid  (stg_valid[k]),
        .out_payload(stg_payload[k])
      );
    end
  end

  // Post-edge occupancy, so FLUSH exits on the cycle of the final delivery.
  always_comb begin
    logic prev_v;
    pipe_empty_d = 1'b1;
    prev_v       = accept;
    for (int k = 0; k < int'(depth); k++) begin
      if (stg_en[k] ? prev_v : stg_valid[k]) pipe_empty_d = 1'b0;
      prev_v = stg_valid[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = ACTIVE;
      ACTIVE:  if (bus.flush)    state_d = FLUSH;
      FLUSH:   if (pipe_empty_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear applies before the same-cycle accept update.
  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    if (bus.clear) begin
      count_d = '0;
      max_d   = '0;
    end
    if (accept) begin
      count_d = count_d + size'(1);
      max_d   = (bus.src2 > max_d) ? bus.src2 : max_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
    end
  end

  assign bus.out_valid                  = stg_valid[depth-1];
  assign {bus.out1, bus.out2, bus.out3} = stg_payload[depth-1];
  assign bus.out4                       = count_q;
  assign bus.out5                       = max_q;
  assign bus.busy                       = (state_q != IDLE);

endmodule

// File: tb/tb_ff_comb_pipe.sv
// Directed bench for ff_comb_pipe across three size/depth configurations.
module tb_ff_comb_pipe;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ff_comb_pipe_if #(.size(4)) ia ();
  ff_comb_pipe_if #(.size(2)) ib ();
  ff_comb_pipe_if #(.size(3)) ic ();

  ff_comb_pipe #(.size(4), .depth(2)) u_a (.clk(clk), .reset(reset), .bus(ia));
  ff_comb_pipe #(.size(2), .depth(3)) u_b (.clk(clk), .reset(reset), .bus(ib));
  ff_comb_pipe #(.size(3), .depth(2)) u_c (.clk(clk), .reset(reset), .bus(ic));

  typedef struct {
    logic [3:0] s1, s2, s3;
    logic [3:0] e1, e2, e3;
  } vec_t;

  vec_t tab_a [7];
  vec_t tab_b [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;

    {ia.in_valid, ia.flush, ia.clear, ia.out_ready} = '0;
    {ia.src1, ia.src2, ia.src3} = '0;
    {ib.in_valid, ib.flush, ib.clear, ib.out_ready} = '0;
    {ib.src1, ib.src2, ib.src3} = '0;
    {ic.in_valid, ic.flush, ic.clear, ic.out_ready} = '0;
    {ic.src1, ic.src2, ic.src3} = '0;

    // {src1, src2, src3, out1, out2, out3} for size 4
    tab_a[0] = '{4'd3,  4'd5,  4'd9,  4'd3,  4'd3,  4'd0};
    tab_a[1] = '{4'd6,  4'd2,  4'd9,  4'd6,  4'd9,  4'd6};
    tab_a[2] = '{4'd0,  4'd0,  4'd15, 4'd0,  4'd15, 4'd6};
    tab_a[3] = '{4'd15, 4'd14, 4'd2,  4'd15, 4'd2,  4'd3};
    tab_a[4] = '{4'd7,  4'd8,  4'd4,  4'd7,  4'd7,  4'd3};
    tab_a[5] = '{4'd10, 4'd11, 4'd12, 4'd10, 4'd10, 4'd5};
    tab_a[6] = '{4'd1,  4'd15, 4'd0,  4'd1,  4'd1,  4'd1};
    // size 2: out3 is the decode truncated to 2 bits
    tab_b[0] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
    tab_b[1] = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    tab_b[2] = '{4'd2, 4'd3, 4'd1, 4'd2, 4'd2, 4'd0};

    // Reset state
    step();
    chk("rst_out_valid", 32'(ia.out_valid), 0);
    chk("rst_out1",      32'(ia.out1), 0);
    chk("rst_out4",      32'(ia.out4), 0);
    chk("rst_out5",      32'(ia.out5), 0);
    chk("rst_busy",      32'(ia.busy), 0);
    chk("rst_in_ready",  32'(ia.in_ready), 1);
    #4 reset = 1'b0;

    // Full-throughput stream, latency 2
    ia.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        ia.in_valid = 1'b1;
        ia.src1 = tab_a[i].s1;
        ia.src2 = tab_a[i].s2;
        ia.src3 = tab_a[i].s3;
      end else begin
        ia.in_valid = 1'b0;
      end
      #1;
      if (i < 7) chk("a_in_ready", 32'(ia.in_ready), 1);
      step();
      if (i == 0) chk("a_lat_not_yet", 32'(ia.out_valid), 0);
      if (i >= 1) begin
        chk("a_out_valid", 32'(ia.out_valid), 1);
        chk("a_out1", 32'(ia.out1), 32'(tab_a[i-1].e1));
        chk("a_out2", 32'(ia.out2), 32'(tab_a[i-1].e2));
        chk("a_out3", 32'(ia.out3), 32'(tab_a[i-1].e3));
      end
    end
    step();
    chk("a_drained_valid", 32'(ia.out_valid), 0);
    chk("a_hold_out1",     32'(ia.out1), 1);
    chk("a_count",         32'(ia.out4), 7);
    chk("a_max",           32'(ia.out5), 15);
    chk("a_busy_active",   32'(ia.busy), 1);

    // Fill with backpressure, then flush with two in flight
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.src1 = 4'd2; ia.src2 = 4'd4; ia.src3 = 4'd6;
    step();
    ia.src1 = 4'd9; ia.src2 = 4'd1; ia.src3 = 4'd8;
    step();
    ia.src1 = 4'd5; ia.src2 = 4'd5; ia.src3 = 4'd5;
    #1;
    chk("a_full_in_ready", 32'(ia.in_ready), 0);
    step();
    chk("a_stall_head", 32'(ia.out1), 2);
    ia.flush = 1'b1; ia.out_ready = 1'b1;
    #1;
    chk("a_flush_in_ready", 32'(ia.in_ready), 0);
    step();
    ia.flush = 1'b0;
    chk("a_flush_busy1",  32'(ia.busy), 1);
    chk("a_flush_out1",   32'(ia.out1), 9);
    chk("a_flush_out2",   32'(ia.out2), 8);
    chk("a_flush_out3",   32'(ia.out3), 1);
    chk("a_flush_count",  32'(ia.out4), 9);
    #1;
    chk("a_flushing_in_ready", 32'(ia.in_ready), 0);
    step();
    ia.in_valid = 1'b0;
    chk("a_flush_idle_busy",  32'(ia.busy), 0);
    chk("a_flush_idle_valid", 32'(ia.out_valid), 0);
    chk("a_flush_no_accept",  32'(ia.out4), 9);

    // Flush in IDLE is ignored
    ia.flush = 1'b1;
    #1;
    chk("a_idle_flush_in_ready", 32'(ia.in_ready), 1);
    step();
    chk("a_idle_flush_busy", 32'(ia.busy), 0);
    ia.flush = 1'b0;

    // depth 3 stall: only three of five offers accepted, then in-order drain
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      ib.in_valid = 1'b1;
      ib.src1 = (acc < 3) ? tab_b[acc].s1[1:0] : 2'd3;
      ib.src2 = (acc < 3) ? tab_b[acc].s2[1:0] : 2'd3;
      ib.src3 = (acc < 3) ? tab_b[acc].s3[1:0] : 2'd3;
      #1;
      if (ib.in_ready === 1'b1) acc++;
      step();
    end
    chk("b_accepted", 32'(acc), 3);
    chk("b_stall_in_ready", 32'(ib.in_ready), 0);
    chk("b_count", 32'(ib.out4), 3);
    chk("b_max",   32'(ib.out5), 3);
    ib.in_valid = 1'b0;
    ib.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("b_out_valid", 32'(ib.out_valid), 1);
      chk("b_out1", 32'(ib.out1), 32'(tab_b[j].e1));
      chk("b_out2", 32'(ib.out2), 32'(tab_b[j].e2));
      chk("b_out3", 32'(ib.out3), 32'(tab_b[j].e3));
      step();
    end
    chk("b_drained", 32'(ib.out_valid), 0);

    // size 3 counter wrap, then clear with a same-cycle accept
    ic.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ic.in_valid = 1'b1;
      ic.src2 = 3'(i);
      #1;
      if (i == 7) chk("c_count_top", 32'(ic.out4), 7);
      step();
    end
    chk("c_wrap", 32'(ic.out4), 0);
    chk("c_max",  32'(ic.out5), 7);
    ic.clear = 1'b1; ic.src2 = 3'd6;
    step();
    ic.in_valid = 1'b0;
    chk("c_clear_accept_count", 32'(ic.out4), 1);
    chk("c_clear_accept_max",   32'(ic.out5), 6);
    step();
    ic.clear = 1'b0;
    chk("c_clear_count", 32'(ic.out4), 0);
    chk("c_clear_max",   32'(ic.out5), 0);

    // Async reset in the middle of a stall
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.src1 = 4'd1; ia.src2 = 4'd2; ia.src3 = 4'd3;
    step();
    ia.src1 = 4'd4; ia.src2 = 4'd5; ia.src3 = 4'd6;
    step();
    ia.in_valid = 1'b0;
    chk("r_pre_valid", 32'(ia.out_valid), 1);
    chk("r_pre_count", 32'(ia.out4), 11);
    #2 reset = 1'b1;
    #1;
    chk("r_valid", 32'(ia.out_valid), 0);
    chk("r_out1",  32'(ia.out1), 0);
    chk("r_out2",  32'(ia.out2), 0);
    chk("r_out3",  32'(ia.out3), 0);
    chk("r_out4",  32'(ia.out4), 0);
    chk("r_out5",  32'(ia.out5), 0);
    chk("r_busy",  32'(ia.busy), 0);
    #3 reset = 1'b0;
    step();
    chk("r_post_valid", 32'(ia.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
